// File: rtl/key_filter_pkg.sv
// Shared definitions for the key_filter push-button conditioner: channel
// state encoding, counter width and the 1 ms tick divider helpers.
package key_filter_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_W = 2'd1,
    HELD    = 2'd2,
    REL_W   = 2'd3
  } ch_state_t;

  function automatic int ms_tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One debounced key channel: press/release acceptance FSM, hold counter and
// long-press flag. Defining KEY_REPEAT_EN adds auto-repeat after key_long.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_level
);

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS >= 65536 || LONG_MS < 1 || LONG_MS >= 65536 ||
      REPEAT_MS < 1 || REPEAT_MS >= 65536) begin : g_param_err
    $error("key_filter_ch: timing parameters out of range");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             press_nxt, release_nxt, long_nxt, level_nxt;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] rpt, rpt_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rcnt_nxt    = rcnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    level_nxt   = key_level;
`ifdef KEY_REPEAT_EN
    rpt_nxt     = rpt;
`endif
    case (state)
      IDLE: begin
        if (!sync) begin
          state_nxt = PRESS_W;
          cnt_nxt   = '0;
        end
      end
      PRESS_W: begin
        if (sync) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
            level_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_nxt   = '0;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (tick && cnt != CNT_MAX) begin
          cnt_nxt  = cnt + 1'b1;
          long_nxt = (cnt == LONG_M1);
        end
`ifdef KEY_REPEAT_EN
        // Repeat schedule starts on the first tick after key_long and is frozen in REL_W.
        if (tick && cnt >= LONG_CNT) begin
          if (rpt == REP_LAST) begin
            rpt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt + 1'b1;
          end
        end
`endif
        if (sync) begin
          state_nxt = REL_W;
          rcnt_nxt  = '0;
        end
      end
      REL_W: begin
        if (!sync) begin
          state_nxt = HELD;
        end else if (tick) begin
          if (rcnt == DEB_LAST) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            level_nxt   = 1'b0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_level   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rcnt        <= rcnt_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
      key_level   <= level_nxt;
`ifdef KEY_REPEAT_EN
      rpt         <= rpt_nxt;
`endif
    end
  end

endmodule

// File: rtl/key_filter.sv
// Push-button conditioner top: 2-flop synchronisers, shared 1 ms tick and one
// key_filter_ch per key. KEY_REPEAT_EN enables auto-repeat in the channels.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_level
);

  if (CLK_HZ < 1000) begin : g_clk_err
    $error("key_filter: CLK_HZ must be at least 1000");
  end

  localparam int               TICK_DIV = ms_tick_div(CLK_HZ);
  localparam int               DIV_W    = div_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [N_KEYS-1:0] sync_p0, sync_p1;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  // Synchronisers preset to released so reset never fabricates a press edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        tick    <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .sync       (sync_p1[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_level  (key_level[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with a scaled clock (8 cycles per ms tick); events are
// checked against timing windows derived from input edges.
module tb_key_filter;

  localparam int NK     = 4;
  localparam int CLK_HZ = 8000;
  localparam int DEB    = 10;
  localparam int LONG   = 60;
  localparam int REP    = 15;
  localparam int D      = CLK_HZ / 1000;
  localparam int WMAX   = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_press, key_release, key_long, key_level;

  key_filter #(
    .N_KEYS(NK), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB), .LONG_MS(LONG), .REPEAT_MS(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_level(key_level)
  );

  always #5 clk = ~clk;

  int n = 0;
  always @(posedge clk) n <= n + 1;

  // idx = type*4 + key, type 0 press, 1 release, 2 long
  int  act_q[12][$];
  int  lo_q[12][$];
  int  hi_q[12][$];
  bit  saw_all = 1'b0;
  int  errors = 0;
  int  checks = 0;
  bit  wave[NK][WMAX];
  byte lvl[NK][WMAX];

  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (key_press[k])   act_q[k].push_back(n);
      if (key_release[k]) act_q[4+k].push_back(n);
      if (key_long[k])    act_q[8+k].push_back(n);
    end
    if (key_press == 4'hF) saw_all = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed cycle %0d expected in [%0d,%0d]", tag, obs, lo, hi);
    end
  endtask

  // A pulse t ticks after an input edge at cycle s lands in this window (tick phase unknown).
  task automatic expect_ev(input int idx, input int s, input int t);
    lo_q[idx].push_back(s + 4 + (t - 1) * D);
    hi_q[idx].push_back(s + 3 + t * D);
  endtask

  task automatic check_events(input string phase);
    string nm;
    for (int idx = 0; idx < 12; idx++) begin
      nm = $sformatf("%s.%s%0d", phase,
                     (idx < 4) ? "press" : ((idx < 8) ? "release" : "long"), idx % 4);
      chk({nm, ".count"}, act_q[idx].size(), lo_q[idx].size());
      for (int i = 0; i < act_q[idx].size() && i < lo_q[idx].size(); i++)
        chk_win($sformatf("%s[%0d]", nm, i), act_q[idx][i], lo_q[idx][i], hi_q[idx][i]);
      act_q[idx].delete();
      lo_q[idx].delete();
      hi_q[idx].delete();
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic fill(input int k, input int t, input int d, input bit v);
    for (int i = 0; i < d; i++) wave[k][t+i] = v;
  endtask

  initial begin
    int s, base, t, g, total, plo, phi, rlo, rhi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.press", key_press, 0);
    chk("rst.release", key_release, 0);
    chk("rst.long", key_long, 0);
    chk("rst.level", key_level, 0);
    rst = 1'b1;
    idle(12 * D);
    check_events("idle");
    chk("idle.level", key_level, 0);

    // Short press rejected
    key_in = 4'b1101;
    idle(5 * D);
    key_in = 4'hF;
    idle(15 * D);
    check_events("bounce");
    chk("bounce.level", key_level, 0);

    // Clean press / release on key 1
    s = n; key_in = 4'b1101; expect_ev(1, s, DEB);
    idle(20 * D);
    chk("held.level", key_level, 4'b0010);
    s = n; key_in = 4'hF; expect_ev(5, s, DEB);
    idle(15 * D);
    check_events("press1");
    chk("press1.level", key_level, 0);

    // Release chatter during a hold on key 0
    s = n; key_in = 4'b1110; expect_ev(0, s, DEB);
    idle(12 * D);
    for (int i = 0; i < 6; i++) begin
      key_in[0] = ~key_in[0];
      idle(D);
    end
    idle(8 * D);
    chk("toggle.level", key_level, 4'b0001);
    s = n; key_in = 4'hF; expect_ev(4, s, DEB);
    idle(15 * D);
    check_events("toggle");

    // Long hold on key 0
    s = n; key_in = 4'b1110;
    expect_ev(0, s, DEB);
`ifdef KEY_REPEAT_EN
    expect_ev(0, s, DEB + LONG + REP);
    expect_ev(0, s, DEB + LONG + 2 * REP);
`endif
    expect_ev(8, s, DEB + LONG);
    idle((DEB + LONG + 2 * REP + 5) * D);
    s = n; key_in = 4'hF; expect_ev(4, s, DEB);
    idle(15 * D);
    check_events("long");

    // Randomised independent episodes on all keys
    base = n;
    total = 0;
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < WMAX; i++) begin
        wave[k][i] = 1'b1;
        lvl[k][i]  = 0;
      end
      t = 0;
      for (int e = 0; e < 3; e++) begin
        if ($urandom_range(0, 1) == 1) begin
          g = $urandom_range(4, 56); fill(k, t, g, 1'b0); t += g;
          g = $urandom_range(4, 56); fill(k, t, g, 1'b1); t += g;
        end
        expect_ev(k, base + t, DEB);
        g = $urandom_range(96, 128); fill(k, t, g, 1'b0); t += g;
        if ($urandom_range(0, 1) == 1) begin
          g = $urandom_range(4, 56); fill(k, t, g, 1'b1); t += g;
          g = $urandom_range(4, 96); fill(k, t, g, 1'b0); t += g;
        end
        expect_ev(4 + k, base + t, DEB);
        g = $urandom_range(96, 128); fill(k, t, g, 1'b1); t += g;
      end
      if (t + 16 > total) total = t + 16;
      for (int i = 0; i < lo_q[k].size(); i++) begin
        plo = lo_q[k][i] - base;   phi = hi_q[k][i] - base;
        rlo = lo_q[4+k][i] - base; rhi = hi_q[4+k][i] - base;
        for (int j = plo; j <= phi; j++) lvl[k][j] = 2;
        for (int j = phi + 1; j < rlo; j++) lvl[k][j] = 1;
        for (int j = rlo; j <= rhi; j++) lvl[k][j] = 2;
      end
    end
    for (int i = 0; i < total; i++) begin
      if (i % 8 == 4)
        for (int k = 0; k < NK; k++)
          if (lvl[k][i] != 2)
            chk($sformatf("rand.level%0d@%0d", k, i), key_level[k], lvl[k][i]);
      for (int k = 0; k < NK; k++) key_in[k] = wave[k][i];
      @(negedge clk);
    end
    check_events("random");

    // All keys together, reset mid-debounce, then accepted as a fresh press
    key_in = 4'b0000;
    idle(5 * D);
    rst = 1'b0;
    #1;
    chk("rstmid.press", key_press, 0);
    chk("rstmid.level", key_level, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s = n;
    for (int k = 0; k < NK; k++) expect_ev(k, s, DEB);
    saw_all = 1'b0;
    idle(15 * D);
    chk("rstmid.all_same_cycle", saw_all, 1);
    chk("rstmid.level_after", key_level, 4'hF);
    s = n; key_in = 4'hF;
    for (int k = 0; k < NK; k++) expect_ev(4 + k, s, DEB);
    idle(15 * D);
    check_events("rst_mid");

    // Reset while a key is accepted clears level at once
    s = n; key_in = 4'b1011; expect_ev(2, s, DEB);
    idle(20 * D);
    chk("rsthold.level_before", key_level, 4'b0100);
    rst = 1'b0;
    #1;
    chk("rsthold.level_async", key_level, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s = n; expect_ev(2, s, DEB);
    idle(15 * D);
    s = n; key_in = 4'hF; expect_ev(6, s, DEB);
    idle(15 * D);
    check_events("rst_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
